// File: rtl/rom_rd_arbiter_pkg.sv
// Shared types and helpers for the ROM read-port arbiter: FSM state,
// index-width function and the round-robin pick used by the grant logic.
package rom_arb_pkg;

   localparam int MAX_REQ = 8;

   typedef enum logic {
      ARB_FREE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } rr_pick_t;

   function automatic int w_idx(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Scan from the highest offset down so the lowest offset from ptr wins.
   function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                        input int n, input int ptr);
      rr_pick_t r;
      int       i;
      r = '0;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         if (k < n) begin
            i = ptr + k;
            if (i >= n) i = i - n;
            if (req[i[2:0]]) begin
               r.found = 1'b1;
               r.idx   = i[2:0];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rom_rd_arbiter_tag_fifo.sv
// In-order tag FIFO: records which requester owns each outstanding ROM read.
module tag_fifo #(
   parameter int W     = 2,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rom_rd_arbiter.sv
// Round-robin arbiter sharing one rom_mem read port among N_REQ requesters;
// read data is routed back to its issuer through an in-order tag FIFO.
module rom_rd_arbiter
   import rom_arb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int W_ADDR  = 12,
   parameter int W_DATA  = 8,
   parameter int MAX_OUT = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_addr_valid,
   output logic [N_REQ-1:0]        req_addr_ready,
   input  logic [N_REQ*W_ADDR-1:0] req_addr_data,
   output logic [N_REQ-1:0]        rsp_data_valid,
   input  logic [N_REQ-1:0]        rsp_data_ready,
   output logic [W_DATA-1:0]       rsp_data,
   output logic                    mem_addr_valid,
   input  logic                    mem_addr_ready,
   output logic [W_ADDR-1:0]       mem_addr_data,
   input  logic                    mem_data_valid,
   output logic                    mem_data_ready,
   input  logic [W_DATA-1:0]       mem_data
);

   localparam int W_IDX = w_idx(N_REQ);

   arb_state_e       state_q, state_d;
   logic [W_IDX-1:0] lock_idx_q;
   logic [W_IDX-1:0] prio_ptr_q;
   logic [W_IDX-1:0] grant;
   logic             addr_valid;
   logic             addr_hs;
   rr_pick_t         pick;
   logic [W_IDX-1:0] head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;

   assign pick = rr_pick(MAX_REQ'(req_addr_valid), N_REQ, int'(prio_ptr_q));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ARB_FREE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_FREE:   if (addr_valid && !mem_addr_ready) state_d = ARB_LOCKED;
         ARB_LOCKED: if (addr_hs) state_d = ARB_FREE;
         default:    state_d = ARB_FREE;
      endcase
   end

   // A full tag FIFO blocks the grant even if a pop lands this cycle.
   always_comb begin
      grant      = W_IDX'(pick.idx);
      addr_valid = pick.found && !fifo_full;
      if (state_q == ARB_LOCKED) begin
         grant      = lock_idx_q;
         addr_valid = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lock_idx_q <= '0;
         prio_ptr_q <= '0;
      end else begin
         if (state_q == ARB_FREE && addr_valid && !mem_addr_ready) lock_idx_q <= grant;
         if (addr_hs)
            prio_ptr_q <= (grant == W_IDX'(N_REQ - 1)) ? '0 : grant + W_IDX'(1);
      end
   end

   assign mem_addr_valid = rst && addr_valid;
   assign addr_hs        = mem_addr_valid && mem_addr_ready;
   assign mem_addr_data  = rst ? req_addr_data[int'(grant)*W_ADDR +: W_ADDR] : '0;

   always_comb begin
      req_addr_ready = '0;
      if (addr_hs) req_addr_ready[grant] = 1'b1;
   end

   tag_fifo #(
      .W     (W_IDX),
      .DEPTH (MAX_OUT)
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (addr_hs),
      .pop   (pop),
      .din   (grant),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Memory data with no outstanding tag is never accepted.
   assign mem_data_ready = rst && !fifo_empty && rsp_data_ready[head];
   assign pop            = mem_data_valid && mem_data_ready;
   assign rsp_data       = rst ? mem_data : '0;

   always_comb begin
      rsp_data_valid = '0;
      if (rst && mem_data_valid && !fifo_empty) rsp_data_valid[head] = 1'b1;
   end

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// Directed bench for rom_rd_arbiter with a queue-based reference model.
module tb_rom_rd_arbiter;

   localparam int N  = 4;
   localparam int WA = 12;
   localparam int WD = 8;
   localparam int MO = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_addr_valid;
   logic [N-1:0]    req_addr_ready;
   logic [N*WA-1:0] req_addr_data;
   logic [N-1:0]    rsp_data_valid;
   logic [N-1:0]    rsp_data_ready;
   logic [WD-1:0]   rsp_data;
   logic            mem_addr_valid;
   logic            mem_addr_ready;
   logic [WA-1:0]   mem_addr_data;
   logic            mem_data_valid;
   logic            mem_data_ready;
   logic [WD-1:0]   mem_data;

   int errors = 0;
   int checks = 0;

   rom_rd_arbiter #(.N_REQ(N), .W_ADDR(WA), .W_DATA(WD), .MAX_OUT(MO)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_addr_valid (req_addr_valid),
      .req_addr_ready (req_addr_ready),
      .req_addr_data  (req_addr_data),
      .rsp_data_valid (rsp_data_valid),
      .rsp_data_ready (rsp_data_ready),
      .rsp_data       (rsp_data),
      .mem_addr_valid (mem_addr_valid),
      .mem_addr_ready (mem_addr_ready),
      .mem_addr_data  (mem_addr_data),
      .mem_data_valid (mem_data_valid),
      .mem_data_ready (mem_data_ready),
      .mem_data       (mem_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: outstanding owners as a queue, pointer and lock as plain ints.
   int mq[$];
   int mptr      = 0;
   bit mlocked   = 0;
   int mlock_idx = 0;

   function automatic void mdl(output bit vexp, output int g, output logic [N-1:0] ardy,
                               output logic [N-1:0] rv, output logic mdr);
      bit found;
      int i;
      vexp  = 0;
      g     = 0;
      found = 0;
      if (mlocked) begin
         g    = mlock_idx;
         vexp = 1;
      end else begin
         for (int k = 0; k < N; k++) begin
            i = (mptr + k) % N;
            if (!found && req_addr_valid[i[1:0]]) begin
               found = 1;
               g     = i;
               vexp  = (mq.size() < MO);
            end
         end
      end
      ardy = (vexp && mem_addr_ready) ? 4'(1 << g) : '0;
      rv   = '0;
      mdr  = 1'b0;
      if (mq.size() > 0) begin
         i   = mq[0];
         rv  = mem_data_valid ? 4'(1 << i) : '0;
         mdr = rsp_data_ready[i[1:0]];
      end
   endfunction

   always @(posedge clk or negedge rst) begin
      bit            v;
      int            g;
      logic [N-1:0]  a, r;
      logic          d;
      if (!rst) begin
         mq.delete();
         mptr    = 0;
         mlocked = 0;
      end else begin
         mdl(v, g, a, r, d);
         if (mem_data_valid && d) void'(mq.pop_front());
         if (v && mem_addr_ready) begin
            mq.push_back(g);
            mptr    = (g + 1) % N;
            mlocked = 0;
         end else if (v) begin
            mlocked   = 1;
            mlock_idx = g;
         end
      end
   end

   always @(negedge clk) begin
      bit            v;
      int            g;
      logic [N-1:0]  a, r;
      logic          d;
      mdl(v, g, a, r, d);
      if (!rst) begin
         v = 0; a = '0; r = '0; d = 1'b0;
      end
      chk("m_addr_valid", 32'(mem_addr_valid), 32'(v));
      chk("m_addr_ready", 32'(req_addr_ready), 32'(a));
      chk("m_rsp_valid",  32'(rsp_data_valid), 32'(r));
      chk("m_data_ready", 32'(mem_data_ready), 32'(d));
      chk("m_rsp_data",   32'(rsp_data), rst ? 32'(mem_data) : 32'h0);
      if (v)         chk("m_addr_data", 32'(mem_addr_data), 32'(req_addr_data[g*WA +: WA]));
      else if (!rst) chk("m_addr_data_rst", 32'(mem_addr_data), 32'h0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic clear_in();
      req_addr_valid = '0;
      rsp_data_ready = '0;
      mem_addr_ready = 1'b0;
      mem_data_valid = 1'b0;
      mem_data       = '0;
   endtask

   task automatic set_addr(input int i, input logic [WA-1:0] a);
      req_addr_data[i*WA +: WA] = a;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_in();
      step();
      step();
      rst = 1'b1;
   endtask

   initial begin
      // Reset: outputs forced low even with every input active.
      rst            = 1'b0;
      req_addr_data  = '0;
      req_addr_valid = '1;
      rsp_data_ready = '1;
      mem_addr_ready = 1'b1;
      mem_data_valid = 1'b1;
      mem_data       = 8'hFF;
      for (int i = 0; i < N; i++) set_addr(i, 12'hF00 + 12'(i));
      #2;
      chk("rst_outputs", 32'({mem_addr_valid, req_addr_ready, rsp_data_valid, mem_data_ready}), 32'h0);
      chk("rst_rsp_data", 32'(rsp_data), 32'h0);
      chk("rst_addr_data", 32'(mem_addr_data), 32'h0);
      do_reset();

      // Single read from requester 2.
      req_addr_valid = 4'b0100;
      set_addr(2, 12'h0A5);
      mem_addr_ready = 1'b1;
      settle();
      chk("t1_addr", 32'(mem_addr_data), 32'h0A5);
      chk("t1_grant", 32'(req_addr_ready), 32'h4);
      step();
      req_addr_valid = '0;
      mem_data_valid = 1'b1;
      mem_data       = 8'h3C;
      rsp_data_ready = '1;
      settle();
      chk("t1_rsp_valid", 32'(rsp_data_valid), 32'h4);
      chk("t1_rsp_data", 32'(rsp_data), 32'h3C);
      step();
      mem_data_valid = 1'b0;
      req_addr_valid = 4'b1001;
      set_addr(0, 12'h010);
      set_addr(3, 12'h033);
      settle();
      chk("t1_ptr3_grant", 32'(req_addr_ready), 32'h8);
      chk("t1_ptr3_addr", 32'(mem_addr_data), 32'h033);
      step();
      do_reset();

      // Round robin with all requesters valid and memory always ready.
      for (int i = 0; i < N; i++) set_addr(i, 12'h100 + 12'(i));
      req_addr_valid = '1;
      mem_addr_ready = 1'b1;
      rsp_data_ready = '1;
      for (int k = 0; k < 5; k++) begin
         mem_data_valid = (k > 0);
         mem_data       = 8'h50 + 8'(k);
         settle();
         chk("t2_grant", 32'(req_addr_ready), 32'(1 << (k % N)));
         chk("t2_addr", 32'(mem_addr_data), 32'h100 + 32'(k % N));
         if (k > 0) chk("t2_rsp", 32'(rsp_data_valid), 32'(1 << ((k - 1) % N)));
         step();
      end
      req_addr_valid = '0;
      mem_data_valid = 1'b1;
      mem_data       = 8'h55;
      settle();
      chk("t2_rsp_last", 32'(rsp_data_valid), 32'h1);
      step();
      do_reset();

      // Lock: requester 1 stalled for 3 cycles, requester 0 arrives mid-stall.
      req_addr_valid = 4'b0010;
      set_addr(1, 12'h111);
      set_addr(0, 12'h200);
      for (int s = 0; s < 3; s++) begin
         if (s == 1) req_addr_valid = 4'b0011;
         settle();
         chk("t3_lock_addr", 32'(mem_addr_data), 32'h111);
         chk("t3_lock_valid", 32'(mem_addr_valid), 32'h1);
         step();
      end
      mem_addr_ready = 1'b1;
      settle();
      chk("t3_hs1", 32'(req_addr_ready), 32'h2);
      chk("t3_hs1_addr", 32'(mem_addr_data), 32'h111);
      step();
      req_addr_valid = 4'b0001;
      settle();
      chk("t3_hs0", 32'(req_addr_ready), 32'h1);
      chk("t3_hs0_addr", 32'(mem_addr_data), 32'h200);
      step();
      do_reset();

      // FIFO full: four reads outstanding block a fifth until one pops.
      req_addr_valid = 4'b0001;
      set_addr(0, 12'h0F0);
      mem_addr_ready = 1'b1;
      repeat (4) step();
      req_addr_valid = 4'b0100;
      set_addr(2, 12'h222);
      settle();
      chk("t4_full_valid", 32'(mem_addr_valid), 32'h0);
      chk("t4_full_ready", 32'(req_addr_ready), 32'h0);
      step();
      mem_data_valid = 1'b1;
      mem_data       = 8'h77;
      rsp_data_ready = '1;
      settle();
      chk("t4_pop_rsp", 32'(rsp_data_valid), 32'h1);
      chk("t4_pop_nogrant", 32'(mem_addr_valid), 32'h0);
      step();
      mem_data_valid = 1'b0;
      settle();
      chk("t4_after_valid", 32'(mem_addr_valid), 32'h1);
      chk("t4_after_grant", 32'(req_addr_ready), 32'h4);
      chk("t4_after_addr", 32'(mem_addr_data), 32'h222);
      step();
      do_reset();

      // Backpressure on requester 3 while it owns the head tag.
      mem_addr_ready = 1'b1;
      req_addr_valid = 4'b1000;
      set_addr(3, 12'h333);
      step();
      req_addr_valid = 4'b0010;
      set_addr(1, 12'h111);
      step();
      req_addr_valid = '0;
      mem_data_valid = 1'b1;
      mem_data       = 8'hA3;
      rsp_data_ready = 4'b0111;
      repeat (2) begin
         settle();
         chk("t5_bp_ready", 32'(mem_data_ready), 32'h0);
         chk("t5_bp_valid", 32'(rsp_data_valid), 32'h8);
         step();
      end
      rsp_data_ready = '1;
      settle();
      chk("t5_rel_ready", 32'(mem_data_ready), 32'h1);
      chk("t5_rel_valid", 32'(rsp_data_valid), 32'h8);
      chk("t5_rel_data", 32'(rsp_data), 32'hA3);
      step();
      mem_data = 8'hB1;
      settle();
      chk("t5_next_valid", 32'(rsp_data_valid), 32'h2);
      chk("t5_next_data", 32'(rsp_data), 32'hB1);
      step();
      settle();
      chk("t5_unsolicited", 32'(mem_data_ready), 32'h0);
      step();
      do_reset();

      // Reset with two reads outstanding.
      mem_addr_ready = 1'b1;
      req_addr_valid = 4'b0100;
      set_addr(2, 12'h222);
      step();
      req_addr_valid = 4'b1000;
      set_addr(3, 12'h333);
      step();
      req_addr_valid = '1;
      mem_data_valid = 1'b1;
      mem_data       = 8'hEE;
      rsp_data_ready = '1;
      settle();
      chk("t6_pre_rsp", 32'(rsp_data_valid), 32'h4);
      rst = 1'b0;
      #1;
      chk("t6_rst_outputs", 32'({mem_addr_valid, req_addr_ready, rsp_data_valid, mem_data_ready}), 32'h0);
      chk("t6_rst_data", 32'({rsp_data, mem_addr_data}), 32'h0);
      step();
      rst = 1'b1;
      settle();
      chk("t6_no_rsp", 32'(rsp_data_valid), 32'h0);
      chk("t6_empty_ready", 32'(mem_data_ready), 32'h0);
      chk("t6_first_grant", 32'(req_addr_ready), 32'h1);
      step();
      clear_in();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rom_rd_arbiter.md
# rom_rd_arbiter

Round-robin arbiter that shares one `rom_mem` read port (address channel and data channel, both valid/ready) between `N_REQ` requesters, such as the feature-fetch and stage-threshold units of the cascade classifier. It grants one address per cycle to the memory. It records the grant index of every accepted address in an in-order tag FIFO. It returns each read word only to the requester that issued it. Arbitration and routing are combinational, and the only storage is the grant lock, the priority pointer and the tag FIFO.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `W_ADDR`, 12, ROM address width
- `W_DATA`, 8, ROM data width
- `MAX_OUT`, 4, maximum reads in flight (tag FIFO depth, power of 2)

Ports:
- `clk`  in  1  sole clock
- `rst`  in  1  asynchronous, active-low reset
- `req_addr_valid`  in  N_REQ  per-requester address valid
- `req_addr_ready`  out  N_REQ  per-requester address ready
- `req_addr_data`  in  N_REQ*W_ADDR  addresses; requester i occupies bits [i*W_ADDR +: W_ADDR]
- `rsp_data_valid`  out  N_REQ  per-requester read-data valid
- `rsp_data_ready`  in  N_REQ  per-requester read-data ready
- `rsp_data`  out  W_DATA  read data, broadcast to all requesters
- `mem_addr_valid`  out  1  to rom_mem `addr1_valid`
- `mem_addr_ready`  in  1  from rom_mem `addr1_ready`
- `mem_addr_data`  out  W_ADDR  to rom_mem `addr1_data`
- `mem_data_valid`  in  1  from rom_mem `data1_valid`
- `mem_data_ready`  out  1  to rom_mem `data1_ready`
- `mem_data`  in  W_DATA  from rom_mem `data1`

## Operation
**Address arbitration, state machine ARB_FREE / ARB_LOCKED:**
- **ARB_FREE:**
  - grant = first requester with `req_addr_valid`=1, searched from `prio_ptr` upward with wrap modulo N_REQ.
  - `mem_addr_valid` = any `req_addr_valid` AND NOT `fifo_full`.
- **ARB_LOCKED:**
  - grant = `lock_idx`; new or higher-priority requests are ignored.
  - `mem_addr_valid` = 1.
- `mem_addr_data` = address of the granted requester.
- `req_addr_ready[g]` = `mem_addr_ready` AND `mem_addr_valid`; every other requester sees 0.
- **Transitions:**
  - FREE→LOCKED when `mem_addr_valid`=1 and `mem_addr_ready`=0; `lock_idx` latches the grant.
  - LOCKED→FREE on the address handshake.
  - FREE stays FREE on a same-cycle handshake.
- **On every address handshake:**
  - push the grant index into the tag FIFO;
  - set `prio_ptr` = (grant+1) mod N_REQ.
- **Full FIFO:** while `fifo_full`=1, no grant is issued, including a same-cycle pop; pushes never depend on pops.
- **Protocol:** a requester must hold valid and address stable until ready. The lock guarantees that `mem_addr_data` is stable to the memory.

**Response routing:**
- h = tag FIFO head.
- `rsp_data_valid[h]` = `mem_data_valid` AND NOT `fifo_empty`; every other requester sees 0.
- `rsp_data` = `mem_data`.
- `mem_data_ready` = `rsp_data_ready[h]` AND NOT `fifo_empty`.
- Pop on the `mem_data_valid` & `mem_data_ready` handshake.
- Empty FIFO: `mem_data_ready`=0. Unsolicited memory data stalls and is never delivered.
- Simultaneous push and pop in one cycle (FIFO not full) is legal; occupancy is unchanged.

## Timing
- Address path requester→memory: 0 cycles, combinational.
- Response path memory→requester: 0 cycles, combinational.
- Tag FIFO: registered write; head is combinational from the read pointer.
- Reads in flight are limited to MAX_OUT. Throughput is 1 address per cycle when the memory accepts every cycle.
- **Reset (`rst`=0, asynchronous):**
  - state = ARB_FREE, `prio_ptr`=0, FIFO empty (pointers 0, count 0);
  - every output is forced to 0 while `rst`=0.
- **Reset mid-operation:**
  - in-flight tags are discarded;
  - rom_mem shares `rst` and is flushed in the same cycle;
  - no response is delivered after reset release.
- Fairness: a requester holding valid is granted within N_REQ address handshakes.

## Structure
- Package `rom_arb_pkg`:
  - `W_IDX` = $clog2(N_REQ) as a function;
  - `arb_state_e` enum {ARB_FREE, ARB_LOCKED};
  - round-robin pick function (request vector, pointer → index, found).
- Sub-module `tag_fifo`:
  - width W_IDX, depth MAX_OUT;
  - ports push, pop, din, dout, full, empty, async active-low `rst`;
  - count register of $clog2(MAX_OUT)+1 bits.
- Top level holds the lock and pointer registers and the combinational muxes.

## Test plan
1. **Single read.** Reset, then requester 2 sends address 0x0A5.
   - Required: `mem_addr_data`=0x0A5, one tag push of 2.
   - Required: the read word reaches only `rsp_data_valid[2]`, and `prio_ptr` becomes 3.
2. **Round robin.** All four requesters hold valid, memory always ready.
   - Required: grant order is 0,1,2,3,0.
   - Required: responses route in the same order.
3. **Lock.** Requester 1 is granted while `mem_addr_ready`=0 for 3 cycles, and requester 0 raises valid during the stall.
   - Required: `mem_addr_data` stays at requester 1's address for all 3 cycles.
   - Required: requester 0 is granted on the next handshake.
4. **FIFO full.** With MAX_OUT=4, issue 4 addresses while withholding `mem_data_valid`.
   - Required: a 5th request sees `mem_addr_valid`=0.
   - Required: after one response pop, the 5th request is granted the following cycle.
5. **Backpressure.** Requester 3's `rsp_data_ready`=0 for 2 cycles while it holds the head tag.
   - Required: `mem_data_ready`=0 for those 2 cycles.
   - Required: the data is delivered once ready rises, with no loss and no reordering.
6. **Reset mid-flight.** Assert `rst`=0 with 2 tags outstanding.
   - Required: all outputs are 0 and the FIFO is empty.
   - Required: after release, requester 0 wins first.
